siu_ncu_xfer_ctl: RTL and testbench
===================================

Name: siu_ncu_xfer_ctl

Overview:
- Sequencer and arbiter on the SII side of the SIU-to-NCU inbound path.
- Shares the single sii_ncu_data link between NUM_SRC requesters: source 0 is the Mondo interrupt queue, source 1 is the PIO completion queue.
- Runs the req/gnt handshake with NCU, then drives one header beat and four payload beats, each with a 2-bit data parity.

Parameters:
NUM_SRC, 2, number of requesting sources (>=1)
GNT_TMO, 256, REQ-state cycles before err_gnt_tmo sets; 0 disables the timeout

Ports:
iol2clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
src_vld  in  NUM_SRC  source i holds a packet
src_hdr  in  32*NUM_SRC  header for source i, slice [32i+31:32i]
src_pld  in  128*NUM_SRC  payload for source i, slice [128i+127:128i]
src_ack  out  NUM_SRC  1-cycle pulse: packet captured; source advances
sii_ncu_req  out  1  request to NCU
ncu_sii_gnt  in  1  NCU grant
sii_ncu_data  out  32  header/payload beat
sii_ncu_dparity  out  2  parity of sii_ncu_data
busy  out  1  state != IDLE
err_unexp_gnt  out  1  sticky: grant seen outside REQ
err_gnt_tmo  out  1  sticky: grant timeout
err_clr  in  1  clears both sticky errors

Behaviour:
- All outputs are registered. Interface: one clock, iol2clk; reset rst is synchronous, active-high.
- Reset:
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - All outputs 0, including sticky errors.
  - Reset mid-transfer abandons the held packet without an ack.
- States: IDLE, REQ, HDR, PL0, PL1, PL2, PL3.
- Arbitration (evaluated in IDLE, and in PL3 for back-to-back packets):
  - Round-robin: search for the first src_vld starting at rr_ptr. Winner w.
  - At that edge: capture src_hdr[w] and src_pld[w] into the hold registers; rr_ptr <= (w+1) mod NUM_SRC.
  - Next cycle: src_ack[w]=1 for exactly one cycle, sii_ncu_req=1, state=REQ.
  - If no src_vld is set, go to (or stay in) IDLE.
- REQ:
  - sii_ncu_req held at 1 until ncu_sii_gnt is sampled at 1 at edge T.
  - Cycle T+1: state=HDR, req=0, data=header.
  - Cycles T+2..T+5: PL0..PL3 drive payload[31:0], [63:32], [95:64], [127:96].
- Outside HDR and PL0..PL3, sii_ncu_data=0 and sii_ncu_dparity=0.
- Parity: dparity[i] = XOR-reduce(data[16i+15:16i]), applied to the header and payload beats.
- Timeout:
  - A counter increments each REQ cycle and clears on leaving REQ; it saturates.
  - When it reaches GNT_TMO (and GNT_TMO != 0), err_gnt_tmo sets.
  - req stays asserted and the transfer completes normally once the grant arrives.
- Unexpected grant: ncu_sii_gnt=1 in any state other than REQ sets err_unexp_gnt; the grant is otherwise ignored.
- err_clr clears both sticky errors. A set in the same cycle wins over the clear.
- Boundary cases:
  - src_vld dropping while in REQ: no effect, the packet is already held.
  - Grant in the same cycle that REQ is entered: not possible, since req is first visible in REQ.

Optional Feature:
SIU_NCU_PERR_INJ_EN
- With the macro: adds input perr_inj (1 bit).
  - A perr_inj pulse arms a flag.
  - The next PL0 beat inverts sii_ncu_dparity[0]; the flag then clears.
  - The flag survives until used; rst clears it.
- Without the macro: no port and no logic; parity is always correct.

Decomposition:
- Package siu_ncu_pkg holds:
  - state encoding;
  - HDR_W=32, PLD_W=128, BEAT_W=32, NUM_BEATS=4;
  - the parity function.
- One sub-module, siu_ncu_rr_arb: rotating-priority winner select from src_vld and rr_ptr, with a one-hot grant output.

Test Plan:
1. Single packet on src0, hdr=0xA5A50001, pld=0x44444444_33333333_22222222_11111111, gnt 3 cycles after req rises.
   - Expect src_ack[0] pulse and req until gnt.
   - Expect data 0xA5A50001 with parity 2'b01 at T+1, then 0x11111111, 0x22222222, 0x33333333, 0x44444444 with parity 2'b00.
   - busy=0 at T+6.
2. src_vld=2'b11 held continuously with immediate gnt:
   - winners alternate 0,1,0,1;
   - exactly one ack per packet;
   - back-to-back packets with no IDLE cycle.
3. GNT_TMO=16 and gnt withheld:
   - err_gnt_tmo=1 after the 16th REQ cycle while req stays 1;
   - a later gnt completes the packet normally;
   - err_clr returns the flag to 0.
4. gnt pulse while IDLE: err_unexp_gnt=1, data stays 0, no state change.
5. rst during PL1:
   - next cycle req=0, data=0, busy=0;
   - the pending src1 packet is re-arbitrated with rr_ptr=0.
6. (SIU_NCU_PERR_INJ_EN) perr_inj pulse, then a packet with pld beat0=0x00000000: PL0 parity=2'b01, all other beats correct.

Source files
------------

// File: rtl/siu_ncu_pkg.sv
// Shared types and helpers for the SII-to-NCU transfer controller.
// Beat geometry, FSM state encoding and beat parity.
package siu_ncu_pkg;

  localparam int HDR_W     = 32;
  localparam int PLD_W     = 128;
  localparam int BEAT_W    = 32;
  localparam int NUM_BEATS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_PL0,
    ST_PL1,
    ST_PL2,
    ST_PL3
  } state_e;

  function automatic logic [1:0] dpar(input logic [BEAT_W-1:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

endpackage

// File: rtl/siu_ncu_xfer_ctl_rr_arb.sv
// Rotating-priority arbiter: first valid source at or after ptr_i.
// Returns a one-hot grant plus the binary winner index.
module siu_ncu_rr_arb #(
  parameter int NUM_SRC = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_SRC-1:0] vld_i,
  input  logic [PW-1:0]      ptr_i,
  output logic               any_o,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);

  logic          found;
  logic [PW-1:0] j;

  always_comb begin
    found = 1'b0;
    j     = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = PW'((int'(ptr_i) + k) % NUM_SRC);
      if (!found && vld_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/siu_ncu_xfer_ctl.sv
// SII-side sequencer/arbiter for the SIU-to-NCU link: req/gnt, header, 4 payload beats.
// Optional parity-error injection on PL0 under `SIU_NCU_PERR_INJ_EN.
module siu_ncu_xfer_ctl
  import siu_ncu_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int GNT_TMO = 256
) (
  input  logic                     iol2clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_vld,
  input  logic [HDR_W*NUM_SRC-1:0] src_hdr,
  input  logic [PLD_W*NUM_SRC-1:0] src_pld,
  output logic [NUM_SRC-1:0]       src_ack,
  output logic                     sii_ncu_req,
  input  logic                     ncu_sii_gnt,
  output logic [BEAT_W-1:0]        sii_ncu_data,
  output logic [1:0]               sii_ncu_dparity,
  output logic                     busy,
  output logic                     err_unexp_gnt,
  output logic                     err_gnt_tmo,
`ifdef SIU_NCU_PERR_INJ_EN
  input  logic                     perr_inj,
`endif
  input  logic                     err_clr
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (GNT_TMO > 1) ? $clog2(GNT_TMO + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(GNT_TMO);

  typedef logic [NUM_BEATS-1:0][BEAT_W-1:0] pld_t;

  state_e            state_q;
  logic [PW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HDR_W-1:0]  hdr_q, hdr_sel;
  pld_t              pld_q, pld_sel;
  logic [NUM_SRC-1:0] ack_q;
  logic              req_q, busy_q;
  logic [BEAT_W-1:0] data_q;
  logic [1:0]        par_q;
  logic              eu_q, eu_d, et_q, et_d;
  logic              arb_any;
  logic [NUM_SRC-1:0] arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              in_req, tmo_hit, unexp_hit, inj_bit;

  siu_ncu_rr_arb #(.NUM_SRC(NUM_SRC), .PW(PW)) u_arb (
    .vld_i (src_vld),
    .ptr_i (rr_q),
    .any_o (arb_any),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    hdr_sel = '0;
    pld_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (arb_gnt[k]) begin
        hdr_sel = hdr_sel | src_hdr[k*HDR_W +: HDR_W];
        pld_sel = pld_sel | src_pld[k*PLD_W +: PLD_W];
      end
    end
  end

  assign rr_d = (arb_idx == PW'(NUM_SRC - 1)) ? '0 : arb_idx + PW'(1);

  // Counter only advances while waiting; it saturates at the limit.
  assign in_req    = (state_q == ST_REQ) && !ncu_sii_gnt;
  assign tmo_hit   = (GNT_TMO != 0) && in_req &&
                     (cnt_q != TMO) && (cnt_q + CW'(1) == TMO);
  assign unexp_hit = ncu_sii_gnt && (state_q != ST_REQ);

  always_comb begin
    cnt_d = '0;
    if (in_req) cnt_d = (cnt_q != TMO) ? cnt_q + CW'(1) : cnt_q;
    et_d = tmo_hit   ? 1'b1 : (err_clr ? 1'b0 : et_q);
    eu_d = unexp_hit ? 1'b1 : (err_clr ? 1'b0 : eu_q);
  end

`ifdef SIU_NCU_PERR_INJ_EN
  logic inj_q;
  always_ff @(posedge iol2clk) begin
    if (rst) inj_q <= 1'b0;
    else if (perr_inj) inj_q <= 1'b1;
    else if (state_q == ST_HDR) inj_q <= 1'b0;
  end
  assign inj_bit = inj_q;
`else
  assign inj_bit = 1'b0;
`endif

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      pld_q   <= '0;
      ack_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      par_q   <= '0;
      eu_q    <= 1'b0;
      et_q    <= 1'b0;
    end else begin
      ack_q  <= '0;
      data_q <= '0;
      par_q  <= '0;
      cnt_q  <= cnt_d;
      eu_q   <= eu_d;
      et_q   <= et_d;
      unique case (state_q)
        ST_IDLE, ST_PL3: begin
          if (arb_any) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            ack_q   <= arb_gnt;
            hdr_q   <= hdr_sel;
            pld_q   <= pld_sel;
            rr_q    <= rr_d;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ncu_sii_gnt) begin
            state_q <= ST_HDR;
            req_q   <= 1'b0;
            data_q  <= hdr_q;
            par_q   <= dpar(hdr_q);
          end
        end
        ST_HDR: begin
          state_q <= ST_PL0;
          data_q  <= pld_q[0];
          par_q   <= dpar(pld_q[0]) ^ {1'b0, inj_bit};
        end
        ST_PL0: begin
          state_q <= ST_PL1;
          data_q  <= pld_q[1];
          par_q   <= dpar(pld_q[1]);
        end
        ST_PL1: begin
          state_q <= ST_PL2;
          data_q  <= pld_q[2];
          par_q   <= dpar(pld_q[2]);
        end
        ST_PL2: begin
          state_q <= ST_PL3;
          data_q  <= pld_q[3];
          par_q   <= dpar(pld_q[3]);
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign src_ack         = ack_q;
  assign sii_ncu_req     = req_q;
  assign sii_ncu_data    = data_q;
  assign sii_ncu_dparity = par_q;
  assign busy            = busy_q;
  assign err_unexp_gnt   = eu_q;
  assign err_gnt_tmo     = et_q;

endmodule

// File: tb/tb_siu_ncu_xfer_ctl.sv
// Self-checking bench for siu_ncu_xfer_ctl (NUM_SRC=2, GNT_TMO=16).
// Per-source packet queues double as the scoreboard, popped on src_ack.
module tb_siu_ncu_xfer_ctl;

  logic         iol2clk = 1'b0;
  logic         rst;
  logic [1:0]   src_vld;
  logic [63:0]  src_hdr;
  logic [255:0] src_pld;
  logic [1:0]   src_ack;
  logic         req;
  logic         gnt;
  logic [31:0]  data;
  logic [1:0]   par;
  logic         busy;
  logic         eu;
  logic         et;
  logic         err_clr;
`ifdef SIU_NCU_PERR_INJ_EN
  logic         perr_inj;
`endif

  siu_ncu_xfer_ctl #(.NUM_SRC(2), .GNT_TMO(16)) dut (
    .iol2clk         (iol2clk),
    .rst             (rst),
    .src_vld         (src_vld),
    .src_hdr         (src_hdr),
    .src_pld         (src_pld),
    .src_ack         (src_ack),
    .sii_ncu_req     (req),
    .ncu_sii_gnt     (gnt),
    .sii_ncu_data    (data),
    .sii_ncu_dparity (par),
    .busy            (busy),
    .err_unexp_gnt   (eu),
    .err_gnt_tmo     (et),
`ifdef SIU_NCU_PERR_INJ_EN
    .perr_inj        (perr_inj),
`endif
    .err_clr         (err_clr)
  );

  always #5 iol2clk = ~iol2clk;

  typedef struct {
    int           src;
    logic [31:0]  hdr;
    logic [127:0] pld;
  } pkt_t;

  typedef struct {
    int           src;
    logic [31:0]  hdr;
    logic [127:0] pld;
    int           dly;
  } vec_t;

  pkt_t       q0[$];
  pkt_t       q1[$];
  pkt_t       cur;
  int         cur_w;
  bit         ack_seen;
  bit         inj_pend = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] obs_par [5];
  vec_t       tbl [6];

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [1:0] bpar(input logic [31:0] d);
    logic [1:0] p;
    p = 2'b00;
    for (int i = 0; i < 32; i++) p[i/16] = p[i/16] ^ d[i];
    return p;
  endfunction

  task automatic drive();
    src_vld[0]       = (q0.size() != 0);
    src_vld[1]       = (q1.size() != 0);
    src_hdr[31:0]    = (q0.size() != 0) ? q0[0].hdr : 32'h0;
    src_hdr[63:32]   = (q1.size() != 0) ? q1[0].hdr : 32'h0;
    src_pld[127:0]   = (q0.size() != 0) ? q0[0].pld : 128'h0;
    src_pld[255:128] = (q1.size() != 0) ? q1[0].pld : 128'h0;
  endtask

  task automatic tick();
    @(negedge iol2clk);
    ack_seen = 1'b0;
    if (src_ack != 2'b00) begin
      chk("ack_onehot", 128'($countones(src_ack)), 128'd1);
      cur_w = src_ack[1] ? 1 : 0;
      if (cur_w == 0 && q0.size() != 0) begin
        cur = q0.pop_front();
        ack_seen = 1'b1;
      end else if (cur_w == 1 && q1.size() != 0) begin
        cur = q1.pop_front();
        ack_seen = 1'b1;
      end else begin
        checks++;
        errors++;
        $display("FAIL ack_empty: ack %b but no packet queued", src_ack);
      end
    end
    drive();
  endtask

  task automatic load(input int s, input logic [31:0] h,
                      input logic [127:0] p);
    pkt_t k;
    k.src = s;
    k.hdr = h;
    k.pld = p;
    if (s == 0) q0.push_back(k);
    else q1.push_back(k);
    drive();
  endtask

  task automatic wait_ack(input string n);
    int k;
    k = 0;
    tick();
    while (!ack_seen && k < 20) begin
      tick();
      k++;
    end
    if (!ack_seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no src_ack within 20 cycles", n);
    end
  endtask

  task automatic xfer(input string n, input int dly, input int nb);
    logic [31:0] eb;
    logic [1:0]  ep;
    chk({n, "_req"}, req, 1);
    for (int d = 0; d < dly; d++) begin
      tick();
      chk({n, "_req_hold"}, req, 1);
      chk({n, "_no_reack"}, src_ack, 0);
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk({n, "_hdr"}, data, cur.hdr);
    chk({n, "_hdr_par"}, par, bpar(cur.hdr));
    chk({n, "_req_drop"}, req, 0);
    chk({n, "_busy"}, busy, 1);
    obs_par[0] = par;
    for (int b = 0; b < nb; b++) begin
      tick();
      eb = cur.pld[32*b +: 32];
      ep = bpar(eb);
      if (b == 0 && inj_pend) begin
        ep[0] = ~ep[0];
        inj_pend = 1'b0;
      end
      chk($sformatf("%s_pl%0d", n, b), data, eb);
      chk($sformatf("%s_pl%0d_par", n, b), par, ep);
      obs_par[b+1] = par;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 32'h0001_0001, {$urandom, $urandom, $urandom, $urandom}, 0};
    tbl[1] = '{1, 32'h8000_0000, {$urandom, $urandom, $urandom, $urandom}, 0};
    tbl[2] = '{0, 32'hFFFF_FFFF, {$urandom, $urandom, $urandom, $urandom}, 0};
    tbl[3] = '{1, 32'h1234_5678, {$urandom, $urandom, $urandom, $urandom}, 0};
    tbl[4] = '{0, 32'hDEAD_BEEF, {$urandom, $urandom, $urandom, $urandom}, 1};
    tbl[5] = '{1, 32'h0000_0003, {$urandom, $urandom, $urandom, $urandom}, 2};

    rst = 1'b1;
    gnt = 1'b0;
    err_clr = 1'b0;
`ifdef SIU_NCU_PERR_INJ_EN
    perr_inj = 1'b0;
`endif
    drive();
    repeat (2) tick();
    chk("rst_req", req, 0);
    chk("rst_data", data, 0);
    chk("rst_par", par, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", src_ack, 0);
    chk("rst_eu", eu, 0);
    chk("rst_et", et, 0);
    rst = 1'b0;

    // single packet, grant a few cycles after req
    load(0, 32'hA5A5_0001, 128'h44444444_33333333_22222222_11111111);
    wait_ack("t1_ack");
    chk("t1_win", cur_w, 0);
    xfer("t1", 3, 4);
    chk("t1_hpar", obs_par[0], 2'b01);
    for (int b = 1; b < 5; b++) chk("t1_ppar", obs_par[b], 2'b00);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_data", data, 0);
    chk("t1_idle_req", req, 0);

    // grant while idle, set-vs-clear priority
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("t4_eu", eu, 1);
    chk("t4_data", data, 0);
    chk("t4_busy", busy, 0);
    chk("t4_req", req, 0);
    chk("t4_et", et, 0);
    tick();
    chk("t4_eu_sticky", eu, 1);
    gnt = 1'b1;
    err_clr = 1'b1;
    tick();
    gnt = 1'b0;
    err_clr = 1'b0;
    chk("t4_set_wins", eu, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", eu, 0);

    // grant timeout (rr_ptr now 1)
    load(1, 32'h0BAD_F00D, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    wait_ack("t3_ack");
    chk("t3_win", cur_w, 1);
    repeat (15) tick();
    chk("t3_et_pre", et, 0);
    chk("t3_req_pre", req, 1);
    tick();
    chk("t3_et_set", et, 1);
    chk("t3_req_hold", req, 1);
    repeat (3) tick();
    chk("t3_et_hold", et, 1);
    xfer("t3", 0, 4);
    tick();
    chk("t3_et_sticky", et, 1);
    chk("t3_busy", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_et_clr", et, 0);

    // both sources valid, immediate grant, back-to-back
    for (int i = 0; i < 6; i++) load(tbl[i].src, tbl[i].hdr, tbl[i].pld);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        wait_ack("t2_ack");
      end else begin
        tick();
        chk($sformatf("t2_b2b%0d", i), ack_seen, 1);
        chk($sformatf("t2_busy%0d", i), busy, 1);
      end
      chk($sformatf("t2_win%0d", i), cur_w, tbl[i].src);
      xfer($sformatf("t2_%0d", i), tbl[i].dly, 4);
    end
    tick();
    chk("t2_idle", busy, 0);

    // reset during PL1 (rr_ptr advances to 1 first)
    load(0, 32'hCAFE_0000, 128'hAAAA5555_12121212_34343434_56565656);
    wait_ack("t5_ack");
    chk("t5_win_a", cur_w, 0);
    load(0, 32'hC0C0_0001, 128'h01010101_02020202_03030303_04040404);
    load(1, 32'hB0B0_0002, 128'h10101010_20202020_30303030_40404040);
    xfer("t5a", 0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_req", req, 0);
    chk("t5_data", data, 0);
    chk("t5_par", par, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ack", src_ack, 0);
    wait_ack("t5_rearb");
    chk("t5_win_c", cur_w, 0);
    xfer("t5c", 0, 4);
    tick();
    chk("t5_b2b", ack_seen, 1);
    chk("t5_win_b", cur_w, 1);
    xfer("t5b", 1, 4);
    tick();
    chk("t5_idle", busy, 0);

`ifdef SIU_NCU_PERR_INJ_EN
    perr_inj = 1'b1;
    tick();
    perr_inj = 1'b0;
    repeat (3) tick();
    inj_pend = 1'b1;
    load(0, 32'h1234_0000, 128'h0F0F0F0F_00FF00FF_13579BDF_00000000);
    wait_ack("t6_ack");
    xfer("t6", 0, 4);
    chk("t6_pl0_par", obs_par[1], 2'b01);
    tick();
    chk("t6_idle", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
